// File: rtl/ibus_responder_pkg.sv
// Shared instruction-bus types plus the responder FSM encoding and default latency.
package ibus_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ibus_resp_state_t;

    localparam int IBUS_RESP_DEFAULT_LATENCY = 2;
    localparam int IBUS_RESP_CNT_W           = 4;

endpackage

// File: rtl/ibus_word_array.sv
// Word-wide instruction array: synchronous write port, combinational read port.
// Contents are deliberately not reset so a loaded program survives a CPU reset.
module ibus_word_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem_r [2**DEPTH_LOG2];

    // Load-port write; a same-edge read still sees the previous word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ibus_responder.sv
// Memory-side instruction-bus responder: one outstanding fetch, fixed LATENCY,
// back-to-back acceptance in the cycle the previous word is returned.
module ibus_responder
    import ibus_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = IBUS_RESP_DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        resetn,
    input  ibus_req_t   ireq,
    output ibus_resp_t  iresp,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);

    localparam logic [IBUS_RESP_CNT_W-1:0] LAT_C = IBUS_RESP_CNT_W'(LATENCY);

    ibus_resp_state_t             state_r, state_s;
    logic [IBUS_RESP_CNT_W-1:0]   cnt_r, cnt_s;
    logic [31:0]                  rdata_r;
    logic                         data_ok_r;
    logic                         busy_r;
    logic                         addr_ok_s;
    logic [31:0]                  rd_word_s;
    logic [DEPTH_LOG2-1:0]        rd_idx_s;
    logic [DEPTH_LOG2-1:0]        wr_idx_s;
    logic                         unused_s;

    assign rd_idx_s = ireq.addr[DEPTH_LOG2+1:2];
    assign wr_idx_s = load_addr[DEPTH_LOG2+1:2];
    assign unused_s = ^{ireq.addr[31:DEPTH_LOG2+2], ireq.addr[1:0],
                        load_addr[31:DEPTH_LOG2+2], load_addr[1:0]};

    ibus_word_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (load_en),
        .waddr (wr_idx_s),
        .wdata (load_data),
        .raddr (rd_idx_s),
        .rdata (rd_word_s)
    );

    // Acceptance window: idle, or the final cycle of the current wait; held low in reset.
    always_comb begin
        addr_ok_s = 1'b0;
        if (!resetn) begin
            addr_ok_s = 1'b0;
        end else if (ireq.valid) begin
            case (state_r)
                IDLE:    addr_ok_s = 1'b1;
                WAIT:    addr_ok_s = (cnt_r == 4'd1);
                default: addr_ok_s = 1'b0;
            endcase
        end else begin
            addr_ok_s = 1'b0;
        end
    end

    // Next-state and latency counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (addr_ok_s) begin
                    state_s = WAIT;
                    cnt_s   = LAT_C;
                end else begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    if (addr_ok_s) begin
                        state_s = WAIT;
                        cnt_s   = LAT_C;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = 4'd0;
                    end
                end else begin
                    state_s = WAIT;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, captured word and registered response flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            rdata_r   <= 32'd0;
            data_ok_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            if (addr_ok_s) begin
                rdata_r <= rd_word_s;
            end else begin
                rdata_r <= rdata_r;
            end
            // data_ok is the registered decode of "next cycle is WAIT with cnt==1".
            data_ok_r <= (state_s == WAIT) && (cnt_s == 4'd1);
            busy_r    <= (state_s == WAIT);
        end
    end

    assign iresp = '{addr_ok: addr_ok_s, data_ok: data_ok_r, data: rdata_r};
    assign busy  = busy_r;

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder: LATENCY=2 instance for most scenarios,
// LATENCY=1 instance for streaming.
module tb_ibus_responder;
    import ibus_responder_pkg::*;

    logic        clk;
    logic        resetn;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy;

    ibus_req_t   ireq1;
    ibus_resp_t  iresp1;
    logic        load_en1;
    logic [31:0] load_addr1;
    logic [31:0] load_data1;
    logic        busy1;

    int checks;
    int failures;

    ibus_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
        .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
    );

    ibus_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .ireq(ireq1), .iresp(iresp1),
        .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load1(input logic [31:0] a, input logic [31:0] d);
        load_en1 = 1'b1; load_addr1 = a; load_data1 = d;
        tick();
        load_en1 = 1'b0;
    endtask

    // Single isolated fetch on the LATENCY=2 instance.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ireq = '{valid: 1'b1, addr: a};
        #1 chk1({tag, "_addr_ok"}, iresp.addr_ok, 1'b1);
        tick();
        ireq.valid = 1'b0;
        #1 chk1({tag, "_c2_data_ok"}, iresp.data_ok, 1'b0);
        tick();
        #1 chk1({tag, "_c3_data_ok"}, iresp.data_ok, 1'b1);
        chk32({tag, "_data"}, iresp.data, exp);
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        resetn = 1'b0;
        ireq = '{valid: 1'b0, addr: 32'd0};
        ireq1 = '{valid: 1'b0, addr: 32'd0};
        load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
        load_en1 = 1'b0; load_addr1 = 32'd0; load_data1 = 32'd0;
        tick();
        tick();

        // Reset values, with valid asserted to show addr_ok is forced low.
        ireq.valid = 1'b1;
        #1 chk1("rst_addr_ok", iresp.addr_ok, 1'b0);
        chk1("rst_data_ok", iresp.data_ok, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_data", iresp.data, 32'd0);
        ireq.valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Basic fetch.
        load(32'hbfc00000, 32'h24080001);
        ireq = '{valid: 1'b1, addr: 32'hbfc00000};
        #1 chk1("basic_c1_addr_ok", iresp.addr_ok, 1'b1);
        chk1("basic_c1_data_ok", iresp.data_ok, 1'b0);
        tick();
        ireq.valid = 1'b0;
        #1 chk1("basic_c2_data_ok", iresp.data_ok, 1'b0);
        chk1("basic_c2_busy", busy, 1'b1);
        tick();
        #1 chk1("basic_c3_data_ok", iresp.data_ok, 1'b1);
        chk32("basic_c3_data", iresp.data, 32'h24080001);
        tick();
        #1 chk1("basic_c4_data_ok", iresp.data_ok, 1'b0);
        chk1("basic_c4_busy", busy, 1'b0);

        // Back-to-back.
        load(32'h0, 32'h11111111);
        load(32'h4, 32'h22222222);
        ireq = '{valid: 1'b1, addr: 32'h0};
        #1 chk1("b2b_c1_addr_ok", iresp.addr_ok, 1'b1);
        tick();
        ireq.addr = 32'h4;
        #1 chk1("b2b_c2_addr_ok", iresp.addr_ok, 1'b0);
        chk1("b2b_c2_data_ok", iresp.data_ok, 1'b0);
        tick();
        #1 chk1("b2b_c3_addr_ok", iresp.addr_ok, 1'b1);
        chk1("b2b_c3_data_ok", iresp.data_ok, 1'b1);
        chk32("b2b_c3_data", iresp.data, 32'h11111111);
        tick();
        ireq.valid = 1'b0;
        #1 chk1("b2b_c4_addr_ok", iresp.addr_ok, 1'b0);
        chk1("b2b_c4_data_ok", iresp.data_ok, 1'b0);
        chk1("b2b_c4_busy", busy, 1'b1);
        tick();
        #1 chk1("b2b_c5_data_ok", iresp.data_ok, 1'b1);
        chk32("b2b_c5_data", iresp.data, 32'h22222222);
        tick();
        #1 chk1("b2b_c6_busy", busy, 1'b0);
        chk1("b2b_c6_data_ok", iresp.data_ok, 1'b0);

        // Load race: same-cycle load to the accepted index returns the old word.
        load(32'h8, 32'hAAAA0000);
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hBBBB0000;
        ireq = '{valid: 1'b1, addr: 32'h8};
        #1 chk1("race_addr_ok", iresp.addr_ok, 1'b1);
        tick();
        load_en = 1'b0;
        ireq.valid = 1'b0;
        tick();
        #1 chk1("race_data_ok", iresp.data_ok, 1'b1);
        chk32("race_old_word", iresp.data, 32'hAAAA0000);
        tick();
        fetch("race_new", 32'h8, 32'hBBBB0000);

        // Reset mid-request.
        ireq = '{valid: 1'b1, addr: 32'h4};
        #1 chk1("rmid_c1_addr_ok", iresp.addr_ok, 1'b1);
        tick();
        ireq.valid = 1'b0;
        resetn = 1'b0;
        #1 chk1("rmid_c2_busy", busy, 1'b0);
        chk1("rmid_c2_data_ok", iresp.data_ok, 1'b0);
        tick();
        ireq.valid = 1'b1;
        #1 chk1("rmid_c3_data_ok", iresp.data_ok, 1'b0);
        chk1("rmid_c3_busy", busy, 1'b0);
        chk1("rmid_c3_addr_ok", iresp.addr_ok, 1'b0);
        tick();
        ireq.valid = 1'b0;
        resetn = 1'b1;
        #1 chk1("rmid_c4_data_ok", iresp.data_ok, 1'b0);
        chk1("rmid_c4_busy", busy, 1'b0);
        tick();
        fetch("rmid_c5", 32'h4, 32'h22222222);

        // Aliasing.
        load(32'h0, 32'hDEADBEEF);
        fetch("alias_1000", 32'h00001000, 32'hDEADBEEF);
        fetch("alias_0003", 32'h00000003, 32'hDEADBEEF);

        // LATENCY=1 streaming.
        load1(32'h0, 32'hA0000001);
        load1(32'h4, 32'hA0000002);
        load1(32'h8, 32'hA0000003);
        load1(32'hC, 32'hA0000004);
        ireq1 = '{valid: 1'b1, addr: 32'h0};
        #1 chk1("l1_c1_addr_ok", iresp1.addr_ok, 1'b1);
        chk1("l1_c1_data_ok", iresp1.data_ok, 1'b0);
        tick();
        ireq1.addr = 32'h4;
        #1 chk1("l1_c2_addr_ok", iresp1.addr_ok, 1'b1);
        chk1("l1_c2_data_ok", iresp1.data_ok, 1'b1);
        chk32("l1_c2_data", iresp1.data, 32'hA0000001);
        tick();
        ireq1.addr = 32'h8;
        #1 chk1("l1_c3_addr_ok", iresp1.addr_ok, 1'b1);
        chk1("l1_c3_data_ok", iresp1.data_ok, 1'b1);
        chk32("l1_c3_data", iresp1.data, 32'hA0000002);
        tick();
        ireq1.addr = 32'hC;
        #1 chk1("l1_c4_addr_ok", iresp1.addr_ok, 1'b1);
        chk1("l1_c4_data_ok", iresp1.data_ok, 1'b1);
        chk32("l1_c4_data", iresp1.data, 32'hA0000003);
        tick();
        ireq1.valid = 1'b0;
        #1 chk1("l1_c5_addr_ok", iresp1.addr_ok, 1'b0);
        chk1("l1_c5_data_ok", iresp1.data_ok, 1'b1);
        chk32("l1_c5_data", iresp1.data, 32'hA0000004);
        tick();
        #1 chk1("l1_c6_data_ok", iresp1.data_ok, 1'b0);
        chk1("l1_c6_busy", busy1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
